// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared constants and types for the FIFO read streamer.
package fifo_rd_stream_pkg;

    localparam int BUF_DEPTH  = 3;
    localparam int BEAT_CNT_W = 16;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// fifo_rd_stream_buf: 3-entry in-order register buffer. Entry 0 is always the
// head; a pop shifts every entry down one slot, and a push lands at the first
// free slot (one lower when a pop happens in the same cycle).
module fifo_rd_stream_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output occ_t                  occ
);

    logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] entry_reg;
    logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] entry_next;
    occ_t                                 occ_reg;
    occ_t                                 occ_next;

    // Per-slot next value: shift down on pop, load the new word at the tail.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        if (gi < BUF_DEPTH - 1) begin : g_mid
            assign entry_next[gi] = pop
                ? ((push && occ_reg == occ_t'(gi + 1)) ? push_data : entry_reg[gi + 1])
                : ((push && occ_reg == occ_t'(gi))     ? push_data : entry_reg[gi]);
        end else begin : g_last
            assign entry_next[gi] = (!pop && push && occ_reg == occ_t'(gi))
                ? push_data : entry_reg[gi];
        end
    end

    // Occupancy: arrival alone +1, transfer alone -1, both together unchanged.
    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + occ_t'(1);
            2'b01:   occ_next = occ_reg - occ_t'(1);
            default: occ_next = occ_reg;
        endcase
    end

    // Buffer storage and occupancy registers; reset clears the head to zero.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            entry_reg <= '0;
            occ_reg   <= '0;
        end else begin
            entry_reg <= entry_next;
            occ_reg   <= occ_next;
        end
    end

    assign head = entry_reg[0];
    assign occ  = occ_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a 1-cycle-latency FIFO read port into a valid/ready
// stream through a 3-entry buffer. Define FIFO_RD_STREAM_CNT_EN to add the
// beat_cnt output counting accepted beats.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  fifo_busy_flag,
    output logic                  enable,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [BEAT_CNT_W-1:0] beat_cnt
`endif
);

    logic inflight_reg;
    logic run_reg;
    logic pop;
    occ_t occ;

    // Read only when the word (plus any word already in flight) has a slot.
    // run_reg keeps enable low until the first clock edge after reset.
    always_comb begin
        enable = run_reg && !fifo_busy_flag
                 && ((3'({1'b0, occ}) + 3'(inflight_reg)) < 3'(BUF_DEPTH));
    end

    assign out_valid = (occ != occ_t'(0));
    assign pop       = out_valid && out_ready;

    // Track the word requested last cycle; it arrives on data this cycle.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            inflight_reg <= 1'b0;
            run_reg      <= 1'b0;
        end else begin
            inflight_reg <= enable;
            run_reg      <= 1'b1;
        end
    end

    fifo_rd_stream_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .res       (res),
        .push      (inflight_reg),
        .push_data (data),
        .pop       (pop),
        .head      (out_data),
        .occ       (occ)
    );

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [BEAT_CNT_W-1:0] beat_cnt_reg;

    // Count accepted beats; wraps naturally at the counter width.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            beat_cnt_reg <= '0;
        end else if (pop) begin
            beat_cnt_reg <= beat_cnt_reg + BEAT_CNT_W'(1);
        end
    end

    assign beat_cnt = beat_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized and directed checks of fifo_rd_stream against
// a queue-based model of the FIFO and of the output buffer.
module tb_fifo_rd_stream;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          res;
    logic          fifo_busy_flag;
    logic          enable;
    logic [DW-1:0] data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0]   beat_cnt;
    logic [15:0]   bc_m;
`endif

    fifo_rd_stream #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .res            (res),
        .fifo_busy_flag (fifo_busy_flag),
        .enable         (enable),
        .data           (data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .beat_cnt       (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] buf_q[$];
    bit            inflight_m;
    bit            run_m;
    bit            en_flag;
    int            mode;
    int            push_pct;
    int            cyc;
    int            n_en;
    int            n_beats;
    int            first_valid;
    bit            quiet;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs at the negedge, advance the model, then
    // drive FIFO data and new stimulus just after the posedge.
    task automatic step();
        bit exp_en;
        bit exp_v;
        bit hs;
        @(negedge clk);
        cyc++;
        exp_v  = (buf_q.size() != 0);
        exp_en = run_m && !fifo_busy_flag && ((buf_q.size() + int'(inflight_m)) < 3);
        check("enable", 32'(enable), 32'(exp_en));
        check("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v) check("out_data", 32'(out_data), 32'(buf_q[0]));
`ifdef FIFO_RD_STREAM_CNT_EN
        check("beat_cnt", 32'(beat_cnt), 32'(bc_m));
`endif
        if (out_valid && first_valid < 0) first_valid = cyc;
        hs = exp_v && out_ready;
        if (hs) begin
            if (!quiet) $display("beat %0d: data 0x%02h", n_beats, buf_q[0]);
            n_beats++;
            void'(buf_q.pop_front());
`ifdef FIFO_RD_STREAM_CNT_EN
            bc_m = bc_m + 16'd1;
`endif
        end
        if (inflight_m) buf_q.push_back(data);
        inflight_m = exp_en;
        en_flag    = exp_en;
        if (exp_en) n_en++;
        @(posedge clk);
        #1;
        if (en_flag) data = fifo_q.pop_front();
        else         data = DW'($urandom);
        if (mode == 1) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < push_pct) fifo_q.push_back(DW'($urandom));
        end else if (mode == 2) begin
            out_ready = 1'b1;
            fifo_q.push_back(DW'($urandom));
        end
        fifo_busy_flag = (fifo_q.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset pulse in mid-cycle, with immediate and held checks.
    task automatic do_reset();
        @(negedge clk);
        #2;
        res = 1'b1;
        #1;
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        buf_q.delete();
        inflight_m = 1'b0;
        run_m      = 1'b0;
        en_flag    = 1'b0;
`ifdef FIFO_RD_STREAM_CNT_EN
        bc_m = 16'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_enable", 32'(enable), 32'd0);
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        res = 1'b0;
        #1;
        check("en_before_edge", 32'(enable), 32'd0);
        run_m = 1'b1;
        cyc   = 0;
        first_valid = -1;
        @(posedge clk);
        #1;
        data = DW'($urandom);
        fifo_busy_flag = (fifo_q.size() == 0);
    endtask

    initial begin
        res = 1'b1;
        fifo_busy_flag = 1'b1;
        out_ready = 1'b0;
        data = '0;
        mode = 0;
        push_pct = 0;
        quiet = 1'b0;
        inflight_m = 1'b0;
        run_m = 1'b0;
        en_flag = 1'b0;
        n_en = 0;
        n_beats = 0;
        first_valid = -1;
`ifdef FIFO_RD_STREAM_CNT_EN
        bc_m = 16'd0;
`endif
        // Streaming: preloaded FIFO, downstream always ready.
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        fifo_busy_flag = 1'b0;
        out_ready = 1'b1;
        do_reset();
        n_beats = 0;
        run(10);
        check("stream_first_valid_cycle", 32'(first_valid), 32'd3);
        check("stream_beats_no_gap", 32'(n_beats), 32'd8);
        run(2);

        // Backpressure: buffer fills to three and holds the head.
        out_ready = 1'b0;
        n_en = 0;
        for (int i = 'h10; i <= 'h15; i++) fifo_q.push_back(DW'(i));
        fifo_busy_flag = 1'b0;
        run(8);
        check("bp_enables", 32'(n_en), 32'd3);
        check("bp_head", 32'(out_data), 32'h10);
        out_ready = 1'b1;
        n_beats = 0;
        run(10);
        check("bp_beats", 32'(n_beats), 32'd6);

        // Empty edge: a single word, then the FIFO runs dry.
        n_en = 0;
        n_beats = 0;
        fifo_q.push_back(8'hA5);
        fifo_busy_flag = 1'b0;
        run(6);
        check("empty_enables", 32'(n_en), 32'd1);
        check("empty_beats", 32'(n_beats), 32'd1);
        check("empty_valid_low", 32'(out_valid), 32'd0);

        // Simultaneous arrival and pop: fill to occ=2 with a word in flight.
        out_ready = 1'b0;
        for (int i = 'h30; i <= 'h37; i++) fifo_q.push_back(DW'(i));
        fifo_busy_flag = 1'b0;
        run(3);
        out_ready = 1'b1;
        n_beats = 0;
        run(12);
        check("simul_beats", 32'(n_beats), 32'd8);

        // Reset mid-stream with two buffered beats and one in flight.
        out_ready = 1'b0;
        for (int i = 'h40; i <= 'h47; i++) fifo_q.push_back(DW'(i));
        fifo_busy_flag = 1'b0;
        run(3);
        do_reset();
        out_ready = 1'b1;
        n_beats = 0;
        run(12);
        check("post_reset_beats", 32'(n_beats), 32'd5);

        // Randomized traffic.
        mode = 1;
        push_pct = 60;
        run(3000);
        mode = 0;
        out_ready = 1'b1;
        run(20);

`ifdef FIFO_RD_STREAM_CNT_EN
        // Counter wrap: 65537 accepted beats leave the counter at 1.
        quiet = 1'b1;
        mode = 2;
        do_reset();
        n_beats = 0;
        for (int i = 0; i < 70000 && n_beats < 65537; i++) step();
        mode = 0;
        check("cnt_transfers", 32'(n_beats), 32'd65537);
        check("beat_cnt_wrap", 32'(beat_cnt), 32'h0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of the FIFO read data and the output stream data.
REQ-002 SHALL have one clock and an asynchronous, active-high reset; the clock port is clk and the reset port is res.
REQ-003 Ports, in order:
- clk  input  1  rising-edge clock, shared with the FIFO read domain.
- res  input  1  asynchronous active-high reset.
- fifo_busy_flag  input  1  FIFO read-side empty flag; 1 means no data.
- enable  output  1  FIFO read strobe; one word is popped per cycle while high.
- data  input  DATA_WIDTH  FIFO read data, valid one cycle after enable.
- out_valid  output  1  output beat available.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_WIDTH  output beat payload.

Function
REQ-004 SHALL drain the FIFO into a 3-entry in-order output buffer and present its head on out_valid/out_data.
REQ-005 SHALL drive enable = !fifo_busy_flag && (occ + inflight < 3), from registered state only; enable SHALL NOT depend combinationally on out_ready.
- occ: buffered beats, 0..3.
- inflight: 1-bit flag, set when enable was high in the previous cycle.
REQ-006 SHALL capture data into the buffer tail in the cycle after enable was high (fixed read latency of 1).
REQ-007 SHALL transfer a beat when out_valid && out_ready, popping the buffer head in that cycle.
REQ-008 out_valid SHALL equal (occ != 0); out_data SHALL be the head entry and SHALL stay stable while out_valid && !out_ready.
REQ-009 Occupancy SHALL follow EMPTY(0) -> ONE -> TWO -> THREE.
- Arrival without transfer: +1.
- Transfer without arrival: -1.
- Arrival and transfer in the same cycle: unchanged.
REQ-010 In steady state, with the FIFO non-empty and out_ready held high, SHALL sustain one beat per cycle after a 2-cycle startup latency (enable to out_valid).
REQ-011 Boundary conditions:
- occ=3, or occ=2 with inflight=1: enable SHALL be low.
- fifo_busy_flag high: enable SHALL be low; buffered beats keep draining.
- No overflow: an in-flight word always has a free slot.
- No underflow: out_valid is never high with occ=0.
REQ-012 SHALL preserve FIFO read order exactly; no beat is dropped or duplicated.

Reset
REQ-013 While res is high: enable=0, out_valid=0, occ=0, inflight=0; out_data SHALL be 0.
REQ-014 Reset asserted mid-operation SHALL discard buffered and in-flight beats immediately (asynchronously).
REQ-015 After res deasserts, the first enable SHALL occur no earlier than the first rising clk edge.

Configuration
REQ-016 Macro FIFO_RD_STREAM_CNT_EN, when defined, SHALL add output beat_cnt [15:0].
- beat_cnt counts transfers (REQ-007) and wraps from 0xFFFF to 0x0000.
- beat_cnt is reset to 0.
REQ-017 Without FIFO_RD_STREAM_CNT_EN, SHALL have no beat_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-018 Package fifo_rd_stream_pkg SHALL hold:
- BUF_DEPTH = 3;
- occ_t, a 2-bit typedef for occupancy;
- BEAT_CNT_W = 16.
REQ-019 Sub-module fifo_rd_stream_buf SHALL implement the 3-entry register buffer (push, pop, head, occ); the top level holds the enable/inflight control and the optional counter.

Verification
REQ-020 Streaming: FIFO preloaded with 0x01..0x08, out_ready=1 -> enable high from cycle 1; out_data 0x01..0x08 on 8 consecutive cycles starting cycle 3; no gaps.
REQ-021 Backpressure: FIFO holds 0x10..0x15, out_ready=0 -> exactly 3 enables; occ=3; out_data held at 0x10; releasing out_ready delivers 0x10..0x15 in order.
REQ-022 Empty edge: fifo_busy_flag goes high after one word (0xA5) -> one enable pulse; one beat 0xA5; out_valid then low; no spurious enable.
REQ-023 Simultaneous: occ=2, inflight=1, out_ready=1 -> arrival and pop in the same cycle; occ stays 2; order preserved.
REQ-024 Reset mid-stream: res pulsed with occ=2 -> out_valid=0 and enable=0 immediately; after release, streaming resumes from the next FIFO word.
REQ-025 With FIFO_RD_STREAM_CNT_EN: 65537 transfers -> beat_cnt = 0x0001 (wrap verified).
